// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing port 0 of a true_dpbram among NUM_REQ requesters,
// with locked bursts and a one-hot tagged read-data return two cycles after acceptance.
module bram_port_arbiter #(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 7,
    parameter int NUM_REQ = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        lock_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ*AWIDTH-1:0] addr_i,
    input  logic [NUM_REQ*DWIDTH-1:0] d_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rvalid_o,
    output logic [DWIDTH-1:0]         rdata_o,
    output logic                      bram_ce_o,
    output logic                      bram_we_o,
    output logic [AWIDTH-1:0]         bram_addr_o,
    output logic [DWIDTH-1:0]         bram_d_o,
    input  logic [DWIDTH-1:0]         bram_q_i
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     owner;
    logic [IDW-1:0]     acc_idx;
    logic               locked;
    logic               acc;
    logic [NUM_REQ-1:0] vld_p1;

    // A locked owner that drops req_i falls straight through to the round-robin
    // search, so a waiting requester is granted in the same cycle.
    always_comb begin : grant_search
        logic found;
        int   idx;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        if (rst) begin
            gnt_o = '0;
        end else if (locked && req_i[owner]) begin
            gnt_o[owner] = 1'b1;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = int'(ptr) + i;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!found && req_i[idx[IDW-1:0]]) begin
                    gnt_o[idx[IDW-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
    end

    // gnt_o is only ever set where req_i is set, so any grant is an accept.
    always_comb begin
        acc     = |gnt_o;
        acc_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_o[i]) acc_idx = IDW'(i);
        end
    end

    assign rdata_o = bram_q_i;

    // Stage p0 -> p1: register the access onto the BRAM port and tag reads.
    // Stage p1 -> p2: the tag lines up with the BRAM's registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            owner       <= '0;
            locked      <= 1'b0;
            bram_ce_o   <= 1'b0;
            bram_we_o   <= 1'b0;
            bram_addr_o <= '0;
            bram_d_o    <= '0;
            vld_p1      <= '0;
            rvalid_o    <= '0;
        end else begin
            bram_ce_o <= acc;
            bram_we_o <= acc & we_i[acc_idx];
            if (acc) begin
                bram_addr_o <= addr_i[acc_idx*AWIDTH +: AWIDTH];
                bram_d_o    <= d_i[acc_idx*DWIDTH +: DWIDTH];
                ptr         <= (int'(acc_idx) == NUM_REQ - 1) ? '0 : acc_idx + 1'b1;
                owner       <= acc_idx;
                locked      <= lock_i[acc_idx];
            end else if (locked && !req_i[owner]) begin
                locked <= 1'b0;
            end
            vld_p1   <= (acc && !we_i[acc_idx]) ? gnt_o : '0;
            rvalid_o <= vld_p1;
        end
    end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Round-robin arbiter that shares port 0 of a `true_dpbram` instance among `NUM_REQ` requesters, such as counter-driven readers and loaders. Each requester issues single-beat read or write accesses through a req/gnt handshake. Beats can be locked into bursts. The arbiter registers the winning access onto the BRAM port and returns the read data to the issuing requester, tagged one-hot, two cycles after acceptance.

## Interface
- `DWIDTH`, 32, data width; must match the BRAM.
- `AWIDTH`, 7, address width; must match the BRAM.
- `NUM_REQ`, 2, number of requesters (2..8).
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `req_i`  in  NUM_REQ  per-requester access request.
- `lock_i`  in  NUM_REQ  keep the grant for the next beat (burst).
- `we_i`  in  NUM_REQ  1 = write, 0 = read.
- `addr_i`  in  NUM_REQ*AWIDTH  requester k uses bits `[k*AWIDTH +: AWIDTH]`.
- `d_i`  in  NUM_REQ*DWIDTH  write data; requester k uses bits `[k*DWIDTH +: DWIDTH]`.
- `gnt_o`  out  NUM_REQ  one-hot grant, combinational from `req_i` and state.
- `rvalid_o`  out  NUM_REQ  one-hot read-data valid.
- `rdata_o`  out  DWIDTH  read data; equals `bram_q_i`.
- `bram_ce_o`, `bram_we_o`  out  1  registered BRAM port-0 enable / write enable.
- `bram_addr_o`  out  AWIDTH  registered BRAM address.
- `bram_d_o`  out  DWIDTH  registered BRAM write data.
- `bram_q_i`  in  DWIDTH  BRAM port-0 read data (1-cycle registered read).

## Operation
- **Reset values:**
  - `bram_ce_o` = 0, `bram_we_o` = 0, `bram_addr_o` = 0, `bram_d_o` = 0.
  - `rvalid_o` = 0.
  - Pointer `ptr` = 0; lock owner cleared.
  - `gnt_o` = 0 while `rst` is high.
- **States:** IDLE and LOCKED.
  - IDLE: round-robin search starting at index `ptr`, wrapping past NUM_REQ-1 to 0. `gnt_o` is the first requester found with `req_i` set; 0 if none.
  - IDLE → LOCKED: an accepted beat from k has `lock_i[k]` = 1. Record `owner` = k.
  - LOCKED: `gnt_o` = `req_i[owner]` on bit `owner` only; all other requesters see gnt = 0.
  - LOCKED → LOCKED: an accepted beat with `lock_i[owner]` = 1.
  - LOCKED → IDLE: an accepted beat with `lock_i[owner]` = 0, or `req_i[owner]` = 0 (no beat, release).
- **Accept:** `req_i[k]` & `gnt_o[k]`. On accept, `ptr` ← (k+1) mod NUM_REQ in both states.
- **Access register:** on accept, `bram_ce_o` ← 1, `bram_we_o` ← `we_i[k]`, and addr/d ← slot k; otherwise `bram_ce_o` ← 0 and `bram_we_o` ← 0. `bram_addr_o` and `bram_d_o` hold their last values.
- **Read return:** a 2-stage valid/ID shift register. A read accepted from k sets `rvalid_o[k]` two cycles later. Writes produce no `rvalid`.
- **Ordering:** at most one accepted beat per cycle, so accesses reach the BRAM in acceptance order. A write then a read to the same address returns the new data.
- Requesters must hold `req_i`, `we_i`, `addr_i` and `d_i` stable until they see gnt.
- `rst` asserted mid-operation: in-flight reads are discarded (`rvalid_o` = 0 from the next cycle), and state returns to IDLE with `ptr` = 0.

## Timing
- Cycle T: `req_i[k]` and `gnt_o[k]` both high (accept).
- T+1: `bram_ce_o` / `bram_we_o` / `bram_addr_o` / `bram_d_o` present the access.
- T+2: `rvalid_o[k]` = 1 and `rdata_o` = memory word (reads only).
- Throughput: one beat per cycle; back-to-back grants to different requesters are allowed.
- No idle cycle between an IDLE grant and a LOCKED burst, or on release.
- NUM_REQ = 1 degenerates to a pass-through with the same latency.

## Test plan
- **Single read:** preload `mem[5]` = 0xA5A5_0005; req0 reads addr 5 at T → `gnt_o` = 01 at T, `bram_ce_o` = 1 / `bram_we_o` = 0 / `bram_addr_o` = 5 at T+1, `rvalid_o` = 01 and `rdata_o` = 0xA5A5_0005 at T+2.
- **Round-robin fairness:** NUM_REQ = 2, both requesters hold reads continuously from reset → grants alternate 01, 10, 01, 10…, and `rvalid_o` alternates with a 2-cycle lag.
- **Write-then-read:** req1 writes 0x1234_5678 to addr 127 (wrap-max address), then reads addr 127 → no `rvalid` for the write; the read returns 0x1234_5678.
- **Locked burst:** req0 performs 4 beats with `lock_i[0]` = 1 on the first 3 beats while req1 requests throughout → `gnt_o` = 01 for 4 cycles, then 10; `ptr` then favours req1.
- **Lock release by drop:** req0 locks, then deasserts req while req1 is waiting → req1 is granted in the cycle req0 drops.
- **Reset mid-flight:** accept a read at T, assert `rst` at T+1 → `rvalid_o` stays 0 at T+2; all outputs at their reset values; the first grant after reset goes to req0.
